// File: rtl/mspu_stream_pkg.sv
// Shared header layout, FSM encodings and length helper for the stream packet dispatcher.
package mspu_stream_pkg;

    localparam int unsigned HdrLenLsb    = 0;
    localparam int unsigned HdrLenW      = 32;
    localparam int unsigned HdrIdLsb     = 32;
    localparam int unsigned HdrIdW       = 32;
    localparam int unsigned HdrDirectBit = 64;
    localparam int unsigned HdrLoadBit   = 65;
    localparam int unsigned HdrBaseLsb   = 128;
    localparam int unsigned HdrBaseW     = 64;

    typedef struct packed {
        logic [HdrBaseW-1:0] base_addr;
        logic                load;
        logic                direct;
        logic [HdrIdW-1:0]   id;
        logic [HdrLenW-1:0]  len;
    } header_t;

    typedef logic [1:0] state_t;

    localparam state_t StIdle   = 2'd0;
    localparam state_t StCheck  = 2'd1;
    localparam state_t StWait   = 2'd2;
    localparam state_t StStream = 2'd3;

    // 33-bit compare so len = 0xFFFFFFFF cannot wrap into the legal range.
    function automatic logic len_illegal(input logic [HdrLenW-1:0] len,
                                         input int unsigned max_beats);
        return (len == '0) || ({1'b0, len} > 33'(max_beats));
    endfunction

endpackage

// File: rtl/stream_beat_counter.sv
// Remaining-beat counter for one packet: loaded with len, decremented on each handshake.
module stream_beat_counter #(
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             step,
    output logic             first,
    output logic             last
);

    logic [WIDTH-1:0] remaining_q;
    logic             first_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            remaining_q <= '0;
            first_q     <= 1'b0;
        end else if (load) begin
            remaining_q <= load_value;
            first_q     <= 1'b1;
        end else if (step) begin
            remaining_q <= remaining_q - WIDTH'(1);
            first_q     <= 1'b0;
        end
    end

    assign first = first_q;
    assign last  = (remaining_q == WIDTH'(1));

endmodule

// File: rtl/stream_packet_dispatcher.sv
// Pops framed packets from a show-ahead receive FIFO and routes them to a core sink,
// or kicks the memory loader; bad-length headers are dropped and counted.
module stream_packet_dispatcher
    import mspu_stream_pkg::*;
#(
    parameter int unsigned CORES      = 4,
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned FIFO_AW    = 11,
    parameter int unsigned MAX_BEATS  = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     recv_fifo_rdreq,
    input  logic [DATA_WIDTH-1:0]    recv_fifo_q,
    input  logic [FIFO_AW-1:0]       recv_fifo_rdusedw,
    input  logic                     recv_fifo_valid,
    input  logic                     core_valid,
    input  logic [$clog2(CORES)-1:0] core_id,
    output logic [$clog2(CORES)-1:0] target_core,
    output logic                     target_core_valid,
    output logic                     target_snk_sop,
    output logic                     target_snk_eop,
    output logic                     target_snk_valid,
    input  logic                     target_snk_ready,
    output logic [DATA_WIDTH-1:0]    target_snk_data,
    output logic                     loader_kick,
    output logic [63:0]              loader_memory_base_addr,
    output logic [31:0]              pkt_count,
    output logic [15:0]              drop_count,
    output logic                     err_drop
);

    localparam int unsigned CoreW = $clog2(CORES);
    localparam int unsigned CntW  = $clog2(MAX_BEATS + 1);

    header_t          head_hdr;
    state_t           state_q, state_d;
    logic [31:0]      len_q;
    logic             direct_q;
    logic [CoreW-1:0] id_core_q;
    logic [CoreW-1:0] target_core_q;
    logic             target_core_valid_q;
    logic             loader_kick_q;
    logic [63:0]      base_addr_q;
    logic [31:0]      pkt_count_q;
    logic [15:0]      drop_count_q;
    logic             err_drop_q;

    logic             enough_data;
    logic             start;
    logic             handshake;
    logic             beat_first;
    logic             beat_last;
    logic             drop;
    logic             kick;
    logic             unused_id_bits;

    assign head_hdr = {recv_fifo_q[HdrBaseLsb +: HdrBaseW],
                       recv_fifo_q[HdrLoadBit],
                       recv_fifo_q[HdrDirectBit],
                       recv_fifo_q[HdrIdLsb +: HdrIdW],
                       recv_fifo_q[HdrLenLsb +: HdrLenW]};

    assign unused_id_bits = ^head_hdr.id[HdrIdW-1:CoreW];

    // Header plus the whole payload must already sit in the FIFO before streaming.
    assign enough_data = (33'(recv_fifo_rdusedw) >= ({1'b0, len_q} + 33'd1));
    assign start       = (state_q == StWait) && enough_data && (direct_q || core_valid);
    assign handshake   = (state_q == StStream) && recv_fifo_valid && target_snk_ready;

    always_comb begin
        state_d         = state_q;
        recv_fifo_rdreq = 1'b0;
        drop            = 1'b0;
        kick            = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (recv_fifo_valid) state_d = StCheck;
            end
            StCheck: begin
                if (len_illegal(head_hdr.len, MAX_BEATS)) begin
                    recv_fifo_rdreq = 1'b1;
                    drop            = 1'b1;
                    state_d         = StIdle;
                end else if (head_hdr.load) begin
                    recv_fifo_rdreq = 1'b1;
                    kick            = 1'b1;
                    state_d         = StIdle;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (start) begin
                    recv_fifo_rdreq = 1'b1;
                    state_d         = StStream;
                end
            end
            StStream: begin
                recv_fifo_rdreq = handshake;
                if (handshake && beat_last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q             <= StIdle;
            len_q               <= '0;
            direct_q            <= 1'b0;
            id_core_q           <= '0;
            target_core_q       <= '0;
            target_core_valid_q <= 1'b0;
            loader_kick_q       <= 1'b0;
            base_addr_q         <= '0;
            pkt_count_q         <= '0;
            drop_count_q        <= '0;
            err_drop_q          <= 1'b0;
        end else begin
            state_q             <= state_d;
            target_core_valid_q <= start;
            loader_kick_q       <= kick;
            err_drop_q          <= drop;
            if (state_q == StCheck) begin
                len_q     <= head_hdr.len;
                direct_q  <= head_hdr.direct;
                id_core_q <= head_hdr.id[CoreW-1:0];
            end
            if (start) target_core_q <= direct_q ? id_core_q : core_id;
            if (kick) base_addr_q <= head_hdr.base_addr;
            if (handshake && beat_last) pkt_count_q <= pkt_count_q + 32'd1;
            if (drop && (drop_count_q != 16'hFFFF)) drop_count_q <= drop_count_q + 16'd1;
        end
    end

    stream_beat_counter #(
        .WIDTH(CntW)
    ) u_beat_counter (
        .clk       (clk),
        .reset     (reset),
        .load      (start),
        .load_value(len_q[CntW-1:0]),
        .step      (handshake),
        .first     (beat_first),
        .last      (beat_last)
    );

    assign target_snk_valid        = (state_q == StStream) && recv_fifo_valid;
    assign target_snk_data         = (state_q == StStream) ? recv_fifo_q : '0;
    assign target_snk_sop          = target_snk_valid && beat_first;
    assign target_snk_eop          = target_snk_valid && beat_last;
    assign target_core             = target_core_q;
    assign target_core_valid       = target_core_valid_q;
    assign loader_kick             = loader_kick_q;
    assign loader_memory_base_addr = base_addr_q;
    assign pkt_count               = pkt_count_q;
    assign drop_count              = drop_count_q;
    assign err_drop                = err_drop_q;

endmodule

// File: tb/tb_stream_packet_dispatcher.sv
// Directed bench for stream_packet_dispatcher with a small show-ahead FIFO model.
module tb_stream_packet_dispatcher;

    localparam int unsigned CORES = 4;
    localparam int unsigned DW    = 256;
    localparam int unsigned AW    = 11;
    localparam int unsigned MAXB  = 1024;
    localparam int unsigned CW    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          recv_fifo_rdreq;
    logic [DW-1:0] recv_fifo_q;
    logic [AW-1:0] recv_fifo_rdusedw;
    logic          recv_fifo_valid;
    logic          core_valid = 1'b0;
    logic [CW-1:0] core_id = '0;
    logic [CW-1:0] target_core;
    logic          target_core_valid;
    logic          target_snk_sop;
    logic          target_snk_eop;
    logic          target_snk_valid;
    logic          target_snk_ready = 1'b0;
    logic [DW-1:0] target_snk_data;
    logic          loader_kick;
    logic [63:0]   loader_memory_base_addr;
    logic [31:0]   pkt_count;
    logic [15:0]   drop_count;
    logic          err_drop;

    always #5 clk = ~clk;

    stream_packet_dispatcher #(
        .CORES(CORES), .DATA_WIDTH(DW), .FIFO_AW(AW), .MAX_BEATS(MAXB)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .recv_fifo_rdreq        (recv_fifo_rdreq),
        .recv_fifo_q            (recv_fifo_q),
        .recv_fifo_rdusedw      (recv_fifo_rdusedw),
        .recv_fifo_valid        (recv_fifo_valid),
        .core_valid             (core_valid),
        .core_id                (core_id),
        .target_core            (target_core),
        .target_core_valid      (target_core_valid),
        .target_snk_sop         (target_snk_sop),
        .target_snk_eop         (target_snk_eop),
        .target_snk_valid       (target_snk_valid),
        .target_snk_ready       (target_snk_ready),
        .target_snk_data        (target_snk_data),
        .loader_kick            (loader_kick),
        .loader_memory_base_addr(loader_memory_base_addr),
        .pkt_count              (pkt_count),
        .drop_count             (drop_count),
        .err_drop               (err_drop)
    );

    // Show-ahead FIFO model: main process pushes, pops happen on rdreq.
    logic [DW-1:0] mem [0:63];
    int rd_ptr = 0;
    int wr_ptr = 0;

    assign recv_fifo_valid   = (wr_ptr != rd_ptr);
    assign recv_fifo_q       = mem[rd_ptr % 64];
    assign recv_fifo_rdusedw = AW'(wr_ptr - rd_ptr);

    always @(posedge clk) if (recv_fifo_rdreq) rd_ptr <= rd_ptr + 1;

    // Sink-side monitor, sampled mid-cycle.
    int hs_cnt = 0, eop_seen = 0, tcv_cnt = 0, kick_cnt = 0, err_cnt = 0;
    int svalid_cnt = 0, stall_err = 0, rdreq_bad = 0;
    logic [CW-1:0] tcv_core = '0;
    logic [DW-1:0] beat_data [0:63];
    logic          beat_sop  [0:63];
    logic          beat_eop  [0:63];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (target_snk_valid) svalid_cnt <= svalid_cnt + 1;
        if (target_snk_valid && target_snk_ready) begin
            beat_data[hs_cnt % 64] <= target_snk_data;
            beat_sop[hs_cnt % 64]  <= target_snk_sop;
            beat_eop[hs_cnt % 64]  <= target_snk_eop;
            hs_cnt <= hs_cnt + 1;
            if (target_snk_eop) eop_seen <= eop_seen + 1;
        end
        if (target_core_valid) begin
            tcv_cnt  <= tcv_cnt + 1;
            tcv_core <= target_core;
        end
        if (loader_kick) kick_cnt <= kick_cnt + 1;
        if (err_drop) err_cnt <= err_cnt + 1;
        if (prev_stall && target_snk_valid && (target_snk_data != prev_data))
            stall_err <= stall_err + 1;
        if (recv_fifo_rdreq && target_snk_valid && !target_snk_ready)
            rdreq_bad <= rdreq_bad + 1;
        prev_stall <= target_snk_valid && !target_snk_ready;
        prev_data  <= target_snk_data;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [DW-1:0] w);
        mem[wr_ptr % 64] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    function automatic logic [DW-1:0] hdr(input logic [31:0] len, input logic [31:0] id,
                                          input logic direct, input logic load,
                                          input logic [63:0] base);
        logic [DW-1:0] h;
        h = '0;
        h[31:0]    = len;
        h[63:32]   = id;
        h[64]      = direct;
        h[65]      = load;
        h[191:128] = base;
        return h;
    endfunction

    function automatic logic [DW-1:0] pay(input int p, input int k);
        return {224'h0, 32'hD000_0000 + 32'(p * 256 + k)};
    endfunction

    task automatic wait_eop(input string tag, input int start_eop, input int budget);
        int n = 0;
        while (eop_seen == start_eop && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, 256'(eop_seen - start_eop), 256'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_rdreq"}, recv_fifo_rdreq, 1'b0);
        check_eq({tag, "_tc"}, target_core, 0);
        check_eq({tag, "_tcv"}, target_core_valid, 1'b0);
        check_eq({tag, "_sop"}, target_snk_sop, 1'b0);
        check_eq({tag, "_eop"}, target_snk_eop, 1'b0);
        check_eq({tag, "_svalid"}, target_snk_valid, 1'b0);
        check_eq({tag, "_data"}, target_snk_data, 0);
        check_eq({tag, "_kick"}, loader_kick, 1'b0);
        check_eq({tag, "_base"}, loader_memory_base_addr, 0);
        check_eq({tag, "_pkt"}, pkt_count, 0);
        check_eq({tag, "_drop_cnt"}, drop_count, 0);
        check_eq({tag, "_err"}, err_drop, 1'b0);
    endtask

    initial begin
        int s_hs, s_eop, s_tcv, s_err, s_rd, s_kick, s_sv, s_stall, s_rdb, n;
        for (int i = 0; i < 64; i++) mem[i] = '0;

        repeat (3) tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // Allocated routing
        core_valid = 1'b1; core_id = 2'd1; target_snk_ready = 1'b1;
        s_hs = hs_cnt; s_eop = eop_seen; s_tcv = tcv_cnt;
        push(hdr(32'd4, 32'd3, 1'b0, 1'b0, 64'd0));
        for (int k = 0; k < 4; k++) push(pay(1, k));
        wait_eop("alloc_done", s_eop, 40);
        tick();
        check_eq("alloc_tcv", 256'(tcv_cnt - s_tcv), 256'd1);
        check_eq("alloc_core", tcv_core, 2'd1);
        check_eq("alloc_beats", 256'(hs_cnt - s_hs), 256'd4);
        for (int k = 0; k < 4; k++) begin
            check_eq("alloc_data", beat_data[(s_hs + k) % 64], pay(1, k));
            check_eq("alloc_sop", beat_sop[(s_hs + k) % 64], k == 0);
            check_eq("alloc_eop", beat_eop[(s_hs + k) % 64], k == 3);
        end
        check_eq("alloc_pkt", pkt_count, 32'd1);

        // Direct routing, no token offered
        core_valid = 1'b0; core_id = 2'd0;
        s_hs = hs_cnt; s_eop = eop_seen; s_tcv = tcv_cnt;
        push(hdr(32'd1, 32'd2, 1'b1, 1'b0, 64'd0));
        push(pay(2, 0));
        wait_eop("direct_done", s_eop, 40);
        tick();
        check_eq("direct_tcv", 256'(tcv_cnt - s_tcv), 256'd1);
        check_eq("direct_core", tcv_core, 2'd2);
        check_eq("direct_beats", 256'(hs_cnt - s_hs), 256'd1);
        check_eq("direct_data", beat_data[s_hs % 64], pay(2, 0));
        check_eq("direct_sop", beat_sop[s_hs % 64], 1'b1);
        check_eq("direct_eop", beat_eop[s_hs % 64], 1'b1);
        check_eq("direct_pkt", pkt_count, 32'd2);

        // Insufficient data: start only once rdusedw reaches len+1
        core_valid = 1'b1; core_id = 2'd3;
        s_hs = hs_cnt; s_eop = eop_seen; s_tcv = tcv_cnt;
        push(hdr(32'd6, 32'd0, 1'b0, 1'b0, 64'd0));
        push(pay(3, 0)); push(pay(3, 1));
        repeat (8) tick();
        check_eq("short3_tcv", 256'(tcv_cnt - s_tcv), 256'd0);
        for (int k = 2; k < 5; k++) begin
            push(pay(3, k));
            tick();
        end
        repeat (4) tick();
        check_eq("short6_tcv", 256'(tcv_cnt - s_tcv), 256'd0);
        check_eq("short6_beats", 256'(hs_cnt - s_hs), 256'd0);
        push(pay(3, 5));
        wait_eop("short_done", s_eop, 40);
        tick();
        check_eq("short_tcv", 256'(tcv_cnt - s_tcv), 256'd1);
        check_eq("short_core", tcv_core, 2'd3);
        check_eq("short_beats", 256'(hs_cnt - s_hs), 256'd6);
        for (int k = 0; k < 6; k++)
            check_eq("short_data", beat_data[(s_hs + k) % 64], pay(3, k));
        check_eq("short_pkt", pkt_count, 32'd3);

        // Backpressure with ready pattern 1,0,0,1
        core_id = 2'd0;
        s_hs = hs_cnt; s_eop = eop_seen; s_stall = stall_err; s_rdb = rdreq_bad;
        push(hdr(32'd6, 32'd0, 1'b0, 1'b0, 64'd0));
        for (int k = 0; k < 6; k++) push(pay(4, k));
        n = 0;
        while (eop_seen == s_eop && n < 100) begin
            target_snk_ready = (n % 4 == 0) || (n % 4 == 3);
            tick();
            n++;
        end
        check_eq("bp_done", 256'(eop_seen - s_eop), 256'd1);
        target_snk_ready = 1'b1;
        tick();
        check_eq("bp_beats", 256'(hs_cnt - s_hs), 256'd6);
        for (int k = 0; k < 6; k++) begin
            check_eq("bp_data", beat_data[(s_hs + k) % 64], pay(4, k));
            check_eq("bp_eop", beat_eop[(s_hs + k) % 64], k == 5);
        end
        check_eq("bp_stable", 256'(stall_err - s_stall), 256'd0);
        check_eq("bp_rdreq", 256'(rdreq_bad - s_rdb), 256'd0);
        check_eq("bp_pkt", pkt_count, 32'd4);

        // Drops: len 0, MAX_BEATS+1, then all-ones
        s_err = err_cnt; s_rd = rd_ptr; s_sv = svalid_cnt; s_tcv = tcv_cnt;
        push(hdr(32'd0, 32'd0, 1'b0, 1'b0, 64'd0));
        repeat (5) tick();
        push(hdr(32'd1025, 32'd0, 1'b0, 1'b0, 64'd0));
        repeat (5) tick();
        check_eq("drop_pulses", 256'(err_cnt - s_err), 256'd2);
        check_eq("drop_count", drop_count, 16'd2);
        check_eq("drop_pops", 256'(rd_ptr - s_rd), 256'd2);
        check_eq("drop_sink", 256'(svalid_cnt - s_sv), 256'd0);
        check_eq("drop_tcv", 256'(tcv_cnt - s_tcv), 256'd0);
        push(hdr(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 64'd0));
        repeat (5) tick();
        check_eq("drop_wrap_count", drop_count, 16'd3);
        check_eq("drop_wrap_pops", 256'(rd_ptr - s_rd), 256'd3);

        // Loader kick
        s_kick = kick_cnt; s_rd = rd_ptr; s_sv = svalid_cnt; s_tcv = tcv_cnt;
        push(hdr(32'd1, 32'd0, 1'b0, 1'b1, 64'h0000_0001_2345_6780));
        repeat (5) tick();
        check_eq("load_kick", 256'(kick_cnt - s_kick), 256'd1);
        check_eq("load_base", loader_memory_base_addr, 64'h0000_0001_2345_6780);
        check_eq("load_tcv", 256'(tcv_cnt - s_tcv), 256'd0);
        check_eq("load_pops", 256'(rd_ptr - s_rd), 256'd1);
        check_eq("load_sink", 256'(svalid_cnt - s_sv), 256'd0);

        // Reset in the middle of a packet
        target_snk_ready = 1'b0; core_valid = 1'b1; core_id = 2'd2;
        push(hdr(32'd4, 32'd0, 1'b0, 1'b0, 64'd0));
        for (int k = 0; k < 4; k++) push(pay(6, k));
        n = 0;
        while (!target_snk_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq("rst_streaming", target_snk_valid, 1'b1);
        target_snk_ready = 1'b1;
        tick();
        target_snk_ready = 1'b0;
        reset = 1'b1;
        tick();
        check_idle_outputs("midrst");
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_packet_dispatcher.md
Name: stream_packet_dispatcher

Overview:
- Parametrised successor to the stream data parser.
- Pops framed packets (one header beat plus N payload beats) from a show-ahead receive FIFO.
- Routes each packet to a core. The core is either allocated from the free-core token interface or named directly by the header. Headers can instead kick the memory loader.
- Adds sink backpressure, length checking with drop, and status counters.
- Sits between the network receive FIFO and the per-core sink multiplexer.

Parameters:
- CORES, 4, number of target cores (≥2).
- DATA_WIDTH, 512, FIFO/sink beat width (≥256).
- FIFO_AW, 11, receive FIFO address width. rdusedw width is FIFO_AW.
- MAX_BEATS, 1024, largest legal payload length. Must be ≤ 2^FIFO_AW−2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- recv_fifo_rdreq  out  1  pop head word
- recv_fifo_q  in  DATA_WIDTH  head word (show-ahead)
- recv_fifo_rdusedw  in  FIFO_AW  words in FIFO, head included
- recv_fifo_valid  in  1  recv_fifo_q holds a valid word
- core_valid  in  1  a free core is offered
- core_id  in  $clog2(CORES)  offered free core
- target_core  out  $clog2(CORES)  core selected for current packet
- target_core_valid  out  1  one-cycle pulse; consumes offered token when allocated
- target_snk_sop  out  1  first payload beat
- target_snk_eop  out  1  last payload beat
- target_snk_valid  out  1  payload beat valid
- target_snk_ready  in  1  selected core accepts beat
- target_snk_data  out  DATA_WIDTH  payload beat
- loader_kick  out  1  one-cycle loader start pulse
- loader_memory_base_addr  out  64  loader base address, held until next kick
- pkt_count  out  32  packets delivered, wraps
- drop_count  out  16  headers dropped, saturates at 0xFFFF
- err_drop  out  1  one-cycle pulse per dropped header

Behaviour:
- Header fields:
  - [31:0] len (payload beats)
  - [63:32] id
  - [64] direct
  - [65] load
  - [191:128] loader base address
- Reset: all outputs 0; FSM to IDLE; counters cleared.
- Reset mid-packet: streaming aborts with no eop. FIFO contents are not flushed by this block.
- IDLE → CHECK when recv_fifo_valid=1.
- CHECK (one cycle, header held in FIFO head, not yet popped):
  - len==0 or len>MAX_BEATS: pop header, pulse err_drop, increment drop_count, go to IDLE. No payload is popped.
  - load=1 (len legal, ignored): pop header, register base addr, pulse loader_kick next cycle, go to IDLE. The loader kick and base address come from the header beat only; the block does not wait for len+1 words.
  - Otherwise go to WAIT.
- WAIT: start only when recv_fifo_rdusedw ≥ len+1 and a core is available.
  - direct=1: core = id[$clog2(CORES)-1:0]; core_valid is ignored.
  - direct=0: requires core_valid=1; core = core_id.
  - On start: pop header, target_core registered, target_core_valid pulsed one cycle, beat counter loaded with len. Go to STREAM.
- STREAM: zero-latency pass-through.
  - target_snk_valid = recv_fifo_valid.
  - target_snk_data = recv_fifo_q.
  - recv_fifo_rdreq = recv_fifo_valid & target_snk_ready.
  - sop on the first beat; eop when remaining == 1.
  - Outputs may change while ready=0 only if valid deasserts. Data is stable while valid=1 and ready=0.
  - On the eop handshake: pkt_count+1, go to IDLE. The next header is examined no earlier than the cycle after.
- target_core holds until the next assignment.
- Simultaneous reset and any event: reset wins.
- len arithmetic: compare in 33 bits so len=0xFFFFFFFF does not wrap.

Decomposition:
- Package mspu_stream_pkg:
  - header field offsets/widths
  - header_t packed struct (len, id, direct, load, base_addr)
  - FSM state enum {IDLE, CHECK, WAIT, STREAM}
- One natural sub-module: stream_beat_counter (load len, decrement on handshake, flags first/last).

Test Plan:
- Allocated routing: core_valid=1, core_id=1; header len=4 id=3 direct=0, rdusedw=5 → one target_core_valid pulse with target_core=1. Four beats follow, sop on beat 1, eop on beat 4. pkt_count=1.
- Direct routing: header len=1 id=2 direct=1, core_valid=0 → target_core=2 with no token needed. A single beat carries sop=eop=1.
- Insufficient data: header len=6, rdusedw rises 3→7 → no target_core_valid until rdusedw=7, then six beats.
- Backpressure: len=6, ready toggles 1,0,0,1… → exactly six handshakes, data stable while ready=0, rdreq only on handshakes.
- Drops: header len=0 and then len=MAX_BEATS+1 → two err_drop pulses, drop_count=2. Only the header words are popped; no sink activity.
- Loader: header load=1, base=0x0000_0001_2345_6780 → loader_kick pulses once, base address output matches, no target_core_valid. Then reset asserted mid-stream of the next packet → all outputs 0 the next cycle.
